// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receiver.
// Holds the receiver FSM state type and the fixed frame-format constants.
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_receive_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Ports: clk_in, rst_in (async, active-high), d_in (async), q_out (synchronized).
// RESET_VAL presets both flops so the output is defined during reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic d_in,
    output logic q_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver with mid-bit sampling of a synchronized serial line.
// Ports: clk_in, rst_in (async, active-high), rx_wire_in (serial, idles high),
//        data_byte_out (last good byte), valid_out (1-cycle strobe),
//        busy_out (frame in progress), frame_err_out (1-cycle bad-stop strobe).
// Build option: define UART_RX_FRAME_ERR_EN to enable frame_err_out;
// otherwise it is tied low and no error logic exists.
module uart_receive
    import uart_pkg::*;
#(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 9600
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rx_wire_in,
    output logic [7:0] data_byte_out,
    output logic       valid_out,
    output logic       busy_out,
    output logic       frame_err_out
);

    localparam int BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_PERIOD     = BAUD_BIT_PERIOD / 2;

    // Terminal counts: a sample is taken on the cycle the counter hits these.
    localparam logic [31:0] BIT_LAST  = 32'(BAUD_BIT_PERIOD - 1);
    localparam logic [31:0] HALF_LAST = 32'(HALF_PERIOD - 1);
    localparam logic [3:0]  BIT_MAX   = 4'(DATA_BITS - 1);

    logic rx_s;

    sync_2ff #(
        .RESET_VAL (IDLE_LEVEL)
    ) u_sync (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   (rx_wire_in),
        .q_out  (rx_s)
    );

    rx_state_e   state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
`ifdef UART_RX_FRAME_ERR_EN
    logic        ferr_q, ferr_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        ferr_d    = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (rx_s == START_BIT) begin
                    state_d   = ST_START;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    // A line back high at mid-start was a glitch.
                    state_d = (rx_s == START_BIT) ? ST_DATA : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_cnt_q == BIT_MAX) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s == STOP_BIT) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
`ifdef UART_RX_FRAME_ERR_EN
                        ferr_d  = 1'b1;
`endif
                        state_d = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_WAIT_HIGH: begin
                // Hold off start detection until the line is released.
                if (rx_s == IDLE_LEVEL) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ferr_q <= 1'b0;
        end else begin
            ferr_q <= ferr_d;
        end
    end

    assign frame_err_out = ferr_q;
`else
    assign frame_err_out = 1'b0;
`endif

    assign data_byte_out = data_q;
    assign valid_out     = valid_q;
    assign busy_out      = (state_q != ST_IDLE);

endmodule
